// File: rtl/fp32_mul_arbiter.sv
// Round-robin arbiter sharing one 2-cycle FP32 multiplier between NUM_REQ requesters.
// Optional issue counter on busy_cycles when FP32_MUL_ARB_PERF_EN is defined.
module fp32_mul_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [31:0]          rsp_data,
    output logic [31:0]          mul_A,
    output logic [31:0]          mul_B,
    output logic                 mul_input_valid,
    input  logic [31:0]          mul_res,
    input  logic                 mul_output_valid,
    input  logic                 flush,
    output logic                 err,
    output logic [31:0]          busy_cycles
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    gnt_id;
    logic               gnt_any;
    logic               hs;

    logic [31:0]        mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic               mul_vld_q, mul_vld_d;
    logic [ID_W-1:0]    iss_id_q, iss_id_d;

    logic               tag0_vld_q, tag0_vld_d, tag0_drop_q, tag0_drop_d;
    logic [ID_W-1:0]    tag0_id_q, tag0_id_d;
    logic               tag1_vld_q, tag1_vld_d, tag1_drop_q, tag1_drop_d;
    logic [ID_W-1:0]    tag1_id_q, tag1_id_d;

    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_data_q, rsp_data_d;
    logic               err_q, err_d;

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        int idx;
        idx     = 0;
        grant   = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!gnt_any && req_valid[idx]) begin
                grant[idx] = 1'b1;
                gnt_id     = ID_W'(idx);
                gnt_any    = 1'b1;
            end
        end
    end

    assign req_ready = resetn ? (grant & {NUM_REQ{~flush}}) : '0;
    assign hs        = gnt_any & ~flush;

    always_comb begin
        rr_ptr_d  = hs ? ID_W'((int'(gnt_id) + 1) % NUM_REQ) : rr_ptr_q;
        mul_a_d   = hs ? req_a[int'(gnt_id)*32 +: 32] : mul_a_q;
        mul_b_d   = hs ? req_b[int'(gnt_id)*32 +: 32] : mul_b_q;
        mul_vld_d = hs;
        iss_id_d  = hs ? gnt_id : iss_id_q;
    end

    // A flush marks every tracked op as drop, including the tail retiring this cycle.
    always_comb begin
        tag0_vld_d  = mul_vld_q;
        tag0_drop_d = flush;
        tag0_id_d   = iss_id_q;
        tag1_vld_d  = tag0_vld_q;
        tag1_drop_d = tag0_drop_q | flush;
        tag1_id_d   = tag0_id_q;
    end

    always_comb begin
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        err_d       = err_q;
        if (tag1_vld_q != mul_output_valid) begin
            err_d = 1'b1;
        end else if (tag1_vld_q && !(tag1_drop_q || flush)) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                rsp_valid_d[i] = (tag1_id_q == ID_W'(i));
            end
            rsp_data_d = mul_res;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr_q    <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_vld_q   <= 1'b0;
            iss_id_q    <= '0;
            tag0_vld_q  <= 1'b0;
            tag0_drop_q <= 1'b0;
            tag0_id_q   <= '0;
            tag1_vld_q  <= 1'b0;
            tag1_drop_q <= 1'b0;
            tag1_id_q   <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            mul_vld_q   <= mul_vld_d;
            iss_id_q    <= iss_id_d;
            tag0_vld_q  <= tag0_vld_d;
            tag0_drop_q <= tag0_drop_d;
            tag0_id_q   <= tag0_id_d;
            tag1_vld_q  <= tag1_vld_d;
            tag1_drop_q <= tag1_drop_d;
            tag1_id_q   <= tag1_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            err_q       <= err_d;
        end
    end

    assign mul_A           = mul_a_q;
    assign mul_B           = mul_b_q;
    assign mul_input_valid = mul_vld_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_data        = rsp_data_q;
    assign err             = err_q;

`ifdef FP32_MUL_ARB_PERF_EN
    logic [31:0] busy_q, busy_d;

    always_comb begin
        busy_d = (mul_vld_q && (busy_q != 32'hFFFF_FFFF)) ? busy_q + 32'd1 : busy_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_cycles = busy_q;
`else
    assign busy_cycles = '0;
`endif

endmodule

// File: tb/tb_fp32_mul_arbiter.sv
// Bench for fp32_mul_arbiter: vector table + scoreboard, with a behavioural 2-cycle multiplier.
module tb_fp32_mul_arbiter;
    logic         clk = 1'b0;
    logic         resetn;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a, req_b;
    logic [3:0]   rsp_valid;
    logic [31:0]  rsp_data;
    logic [31:0]  mul_A, mul_B;
    logic         mul_input_valid;
    logic [31:0]  mul_res;
    logic         mul_output_valid;
    logic         flush;
    logic         err;
    logic [31:0]  busy_cycles;
    logic         inject;

    int nerr = 0;
    int ncheck = 0;
    int cyc = 0;
    bit run = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fp32_mul_arbiter #(.NUM_REQ(4)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .mul_A(mul_A), .mul_B(mul_B), .mul_input_valid(mul_input_valid),
        .mul_res(mul_res), .mul_output_valid(mul_output_valid), .flush(flush),
        .err(err), .busy_cycles(busy_cycles)
    );

    // Exact for normal operands whose product fits the mantissa (truncating).
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [9:0]  e;
        logic [22:0] m;
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {a[31] ^ b[31], 31'd0};
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 10'd1;
        end else begin
            m = p[45:23];
        end
        return {a[31] ^ b[31], e[7:0], m};
    endfunction

    logic        s1v, s2v;
    logic [31:0] s1d, s2d;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1v <= 1'b0; s2v <= 1'b0; s1d <= '0; s2d <= '0;
        end else begin
            s1v <= mul_input_valid;
            s1d <= fp_mul(mul_A, mul_B);
            s2v <= s1v;
            s2d <= s1d;
        end
    end
    assign mul_output_valid = s2v | inject;
    assign mul_res          = s2d;

    localparam logic [31:0] A2 = 32'h4000_0000;
    localparam logic [31:0] A4 = 32'h4080_0000;
    localparam logic [31:0] B_OP [4] = '{32'h3F80_0000, 32'h3FC0_0000, 32'h4040_0000, 32'h3F00_0000};
    localparam logic [31:0] RES  [4] = '{32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 32'h3F80_0000};

    typedef struct {
        logic [3:0] vld;
        logic       fl;
        logic [3:0] rdy;
        logic       alt;
    } vec_t;
    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        ncheck++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s at cycle %0d: got %h, want %h", nm, cyc, act, req);
        end
    endtask

    task automatic add(input logic [3:0] v, input logic f, input logic [3:0] r, input logic alt);
        vec_t t;
        t.vld = v; t.fl = f; t.rdy = r; t.alt = alt;
        vecs.push_back(t);
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) add(4'h0, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic step(input logic [3:0] v, input logic f, input logic [3:0] r, input logic alt);
        exp_t e;
        req_valid = v;
        flush     = f;
        for (int i = 0; i < 4; i++) begin
            req_a[i*32 +: 32] = alt ? A4 : A2;
            req_b[i*32 +: 32] = B_OP[i];
        end
        @(negedge clk);
        chk("req_ready", {28'd0, req_ready}, {28'd0, r});
        if ((v & r) != 4'h0) begin
            for (int i = 0; i < 4; i++) begin
                if (r[i]) e.data = RES[i] + (alt ? 32'h0080_0000 : 32'h0);
            end
            e.id  = r;
            e.cyc = cyc + 4;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Response monitor: each expected result must appear exactly at its cycle.
    always @(negedge clk) begin
        if (resetn && run) begin
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                chk("rsp_valid", {28'd0, rsp_valid}, {28'd0, sb[0].id});
                chk("rsp_data", rsp_data, sb[0].data);
                sb.delete(0);
            end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
                chk("rsp_missing", 32'd0, 32'd1);
                sb.delete(0);
            end else if (rsp_valid != 4'h0) begin
                chk("rsp_unexpected", {28'd0, rsp_valid}, 32'd0);
            end
            if (flush) sb.delete();
        end
    end

    initial begin
        int ptr;
        resetn = 1'b0; req_valid = '0; flush = 1'b0; inject = 1'b0;
        req_a = '0; req_b = '0;

        // all four requesters contend from reset
        for (int i = 0; i < 8; i++) add(4'hF, 1'b0, 4'(1 << (i % 4)), 1'(i % 2));
        add_idle(4);
        // pointer wrap and hold across idle
        add(4'h8, 1'b0, 4'h8, 1'b0);
        add(4'h9, 1'b0, 4'h1, 1'b1);
        add_idle(1);
        add(4'h9, 1'b0, 4'h8, 1'b0);
        add_idle(4);
        // single op: 2.0 * 3.0 from requester 2
        add(4'h4, 1'b0, 4'h4, 1'b0);
        add_idle(4);
        // flush two in-flight ops, then a fresh op
        add(4'h1, 1'b0, 4'h1, 1'b0);
        add(4'h2, 1'b0, 4'h2, 1'b1);
        add(4'h4, 1'b1, 4'h0, 1'b0);
        add(4'h4, 1'b0, 4'h4, 1'b0);
        add_idle(5);
        // flush while the op sits at the tail
        add(4'h1, 1'b0, 4'h1, 1'b1);
        add_idle(2);
        add(4'h0, 1'b1, 4'h0, 1'b0);
        add_idle(4);

        repeat (2) @(posedge clk);
        #1;
        req_valid = 4'hF;
        #1;
        chk("reset_req_ready", {28'd0, req_ready}, 32'd0);
        chk("reset_rsp_valid", {28'd0, rsp_valid}, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);
        chk("reset_mul_valid", {31'd0, mul_input_valid}, 32'd0);
        chk("reset_mul_A", mul_A, 32'd0);
        chk("reset_busy", busy_cycles, 32'd0);
        req_valid = '0;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        run = 1;

        foreach (vecs[k]) step(vecs[k].vld, vecs[k].fl, vecs[k].rdy, vecs[k].alt);
        chk("sb_drained", sb.size(), 32'd0);
        chk("err_after_flush", {31'd0, err}, 32'd0);

        // spurious multiplier output with nothing in flight
        inject = 1'b1;
        @(posedge clk);
        #1;
        inject = 1'b0;
        chk("err_set", {31'd0, err}, 32'd1);
        repeat (3) step(4'h0, 1'b0, 4'h0, 1'b0);
        chk("err_sticky", {31'd0, err}, 32'd1);
        step(4'h0, 1'b1, 4'h0, 1'b0);
        chk("err_flush_keeps", {31'd0, err}, 32'd1);

        run = 0;
        resetn = 1'b0;
        sb.delete();
        #1;
        chk("reset2_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        run = 1;

        ptr = 0;
        for (int i = 0; i < 15; i++) begin
            if (i % 3 == 2) begin
                step(4'h0, 1'b0, 4'h0, 1'b0);
            end else begin
                step(4'hF, 1'b0, 4'(1 << ptr), 1'(i % 2));
                ptr = (ptr + 1) % 4;
            end
        end
        repeat (5) step(4'h0, 1'b0, 4'h0, 1'b0);
`ifdef FP32_MUL_ARB_PERF_EN
        chk("busy_cycles", busy_cycles, 32'd10);
`else
        chk("busy_cycles", busy_cycles, 32'd0);
`endif
        chk("sb_drained_end", sb.size(), 32'd0);
        chk("err_end", {31'd0, err}, 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, ncheck);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1);
    end
endmodule
